// File: rtl/register_rename.sv
// register_rename: maps virtual register numbers to physical register numbers
// ahead of decode/forwarding.
// State: a speculative map, an architectural map and a free-list bit vector.
// A new physical destination is allocated per renamed instruction, the old
// mapping is freed on commit, and a flush rebuilds the speculative state from
// the architectural map.
// Optional feature macro: RENAME_FREE_COUNT_EN adds a registered free_count
// output that holds the popcount of the free vector.
module register_rename #(
  parameter int VREG_WIDTH = 5,
  parameter int PREG_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VREG_WIDTH-1:0] in_rs_addr,
  input  logic [VREG_WIDTH-1:0] in_rt_addr,
  input  logic                  in_rd_enable,
  input  logic [VREG_WIDTH-1:0] in_rd_addr,
  output logic                  out_valid,
  output logic [PREG_WIDTH-1:0] out_prs_addr,
  output logic [PREG_WIDTH-1:0] out_prt_addr,
  output logic [PREG_WIDTH-1:0] out_prd_addr,
  output logic [PREG_WIDTH-1:0] out_prd_old,
  input  logic                  commit_valid,
  input  logic [VREG_WIDTH-1:0] commit_vreg,
  input  logic [PREG_WIDTH-1:0] commit_preg
`ifdef RENAME_FREE_COUNT_EN
  ,
  output logic [PREG_WIDTH:0]   free_count
`endif
);

  localparam int NUM_VREGS = 1 << VREG_WIDTH;
  localparam int NUM_PREGS = 1 << PREG_WIDTH;
  localparam logic [NUM_PREGS-1:0] FREE_RESET =
    {{(NUM_PREGS - NUM_VREGS){1'b1}}, {NUM_VREGS{1'b0}}};

  logic [PREG_WIDTH-1:0] spec_map_q [NUM_VREGS];
  logic [PREG_WIDTH-1:0] spec_map_d [NUM_VREGS];
  logic [PREG_WIDTH-1:0] arch_map_q [NUM_VREGS];
  logic [PREG_WIDTH-1:0] arch_map_d [NUM_VREGS];
  logic [NUM_PREGS-1:0]  free_q, free_d;

  logic                  out_valid_q, out_valid_d;
  logic [PREG_WIDTH-1:0] out_prs_q, out_prs_d;
  logic [PREG_WIDTH-1:0] out_prt_q, out_prt_d;
  logic [PREG_WIDTH-1:0] out_prd_q, out_prd_d;
  logic [PREG_WIDTH-1:0] out_old_q, out_old_d;

  logic                  alloc_need;
  logic                  any_free;
  logic [PREG_WIDTH-1:0] alloc_preg;
  logic                  accept;
  logic                  commit_do;
  logic [PREG_WIDTH-1:0] commit_old;

  // Lowest-numbered free preg from the pre-edge free vector, and the ready decision.
  always_comb begin
    alloc_preg = '0;
    for (int i = NUM_PREGS - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_preg = i[PREG_WIDTH-1:0];
    end
    any_free   = |free_q;
    alloc_need = in_rd_enable && (in_rd_addr != '0);
    in_ready   = !stall && !flush && (!alloc_need || any_free);
    accept     = in_valid && in_ready;
    commit_do  = commit_valid && (commit_vreg != '0);
    commit_old = arch_map_q[commit_vreg];
  end

  // Next-state for maps, free vector and registered outputs; flush overrides rename.
  always_comb begin
    spec_map_d  = spec_map_q;
    arch_map_d  = arch_map_q;
    free_d      = free_q;
    out_valid_d = out_valid_q;
    out_prs_d   = out_prs_q;
    out_prt_d   = out_prt_q;
    out_prd_d   = out_prd_q;
    out_old_d   = out_old_q;

    if (commit_do) arch_map_d[commit_vreg] = commit_preg;

    if (flush) begin
      spec_map_d  = arch_map_d;
      free_d      = '1;
      free_d[0]   = 1'b0;
      for (int i = 0; i < NUM_VREGS; i++) begin
        free_d[arch_map_d[i]] = 1'b0;
      end
      out_valid_d = 1'b0;
    end else begin
      if (!stall) begin
        out_valid_d = accept;
        if (accept) begin
          out_prs_d = spec_map_q[in_rs_addr];
          out_prt_d = spec_map_q[in_rt_addr];
          out_old_d = spec_map_q[in_rd_addr];
          out_prd_d = '0;
          if (alloc_need) begin
            spec_map_d[in_rd_addr] = alloc_preg;
            free_d[alloc_preg]     = 1'b0;
            out_prd_d              = alloc_preg;
          end
        end
      end
      if (commit_do && (commit_old != '0)) free_d[commit_old] = 1'b1;
    end
  end

  // State registers; reset restores identity maps and the upper pregs as free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VREGS; i++) begin
        spec_map_q[i] <= PREG_WIDTH'(i);
        arch_map_q[i] <= PREG_WIDTH'(i);
      end
      free_q      <= FREE_RESET;
      out_valid_q <= 1'b0;
      out_prs_q   <= '0;
      out_prt_q   <= '0;
      out_prd_q   <= '0;
      out_old_q   <= '0;
    end else begin
      spec_map_q  <= spec_map_d;
      arch_map_q  <= arch_map_d;
      free_q      <= free_d;
      out_valid_q <= out_valid_d;
      out_prs_q   <= out_prs_d;
      out_prt_q   <= out_prt_d;
      out_prd_q   <= out_prd_d;
      out_old_q   <= out_old_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_prs_addr = out_prs_q;
  assign out_prt_addr = out_prt_q;
  assign out_prd_addr = out_prd_q;
  assign out_prd_old  = out_old_q;

`ifdef RENAME_FREE_COUNT_EN
  logic [PREG_WIDTH:0] free_count_q, free_count_d;

  // Popcount of the next free vector so the count tracks the same edge.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      free_count_d = free_count_d + {{PREG_WIDTH{1'b0}}, free_d[i]};
    end
  end

  // Free-count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) free_count_q <= (PREG_WIDTH + 1)'(NUM_PREGS - NUM_VREGS);
    else        free_count_q <= free_count_d;
  end

  assign free_count = free_count_q;
`endif

endmodule

// File: tb/tb_register_rename.sv
// Testbench for register_rename: directed stimulus, a behavioural rename model
// compared every cycle, plus hand-computed literal expectations.
module tb_register_rename;

  localparam int VW = 5;
  localparam int PW = 6;
  localparam int NV = 1 << VW;
  localparam int NP = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_rs_addr = '0;
  logic [VW-1:0] in_rt_addr = '0;
  logic          in_rd_enable = 1'b0;
  logic [VW-1:0] in_rd_addr = '0;
  logic          out_valid;
  logic [PW-1:0] out_prs_addr;
  logic [PW-1:0] out_prt_addr;
  logic [PW-1:0] out_prd_addr;
  logic [PW-1:0] out_prd_old;
  logic          commit_valid = 1'b0;
  logic [VW-1:0] commit_vreg = '0;
  logic [PW-1:0] commit_preg = '0;
`ifdef RENAME_FREE_COUNT_EN
  logic [PW:0]   free_count;
`endif

  int total = 0;
  int bad = 0;

  register_rename #(.VREG_WIDTH(VW), .PREG_WIDTH(PW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rs_addr(in_rs_addr),
    .in_rt_addr(in_rt_addr),
    .in_rd_enable(in_rd_enable),
    .in_rd_addr(in_rd_addr),
    .out_valid(out_valid),
    .out_prs_addr(out_prs_addr),
    .out_prt_addr(out_prt_addr),
    .out_prd_addr(out_prd_addr),
    .out_prd_old(out_prd_old),
    .commit_valid(commit_valid),
    .commit_vreg(commit_vreg),
    .commit_preg(commit_preg)
`ifdef RENAME_FREE_COUNT_EN
    ,
    .free_count(free_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: plain integer maps and a free set.
  int sm [NV];
  int am [NV];
  bit fr [NP];
  int e_valid, e_prs, e_prt, e_prd, e_old;

  function automatic int model_free_total();
    int n = 0;
    for (int p = 0; p < NP; p++) if (fr[p]) n++;
    return n;
  endfunction

  function automatic int model_lowest_free();
    for (int p = 0; p < NP; p++) if (fr[p]) return p;
    return -1;
  endfunction

  function automatic int model_ready();
    int need = (in_rd_enable && in_rd_addr != 0) ? 1 : 0;
    if (stall || flush) return 0;
    if (need == 1 && model_free_total() == 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      sm[v] = v;
      am[v] = v;
    end
    for (int p = 0; p < NP; p++) fr[p] = (p >= NV);
    e_valid = 0; e_prs = 0; e_prt = 0; e_prd = 0; e_old = 0;
  endtask

  task automatic model_clock();
    int cv = int'(commit_vreg);
    int cp = int'(commit_preg);
    bit cdo = commit_valid && (cv != 0);
    int rd = int'(in_rd_addr);
    bit need = in_rd_enable && (rd != 0);
    int pick = model_lowest_free();
    bit ok = (model_ready() == 1);
    if (flush) begin
      if (cdo) am[cv] = cp;
      for (int v = 0; v < NV; v++) sm[v] = am[v];
      for (int p = 0; p < NP; p++) fr[p] = (p != 0);
      for (int v = 0; v < NV; v++) fr[am[v]] = 1'b0;
      e_valid = 0;
    end else begin
      if (!stall) begin
        if (in_valid && ok) begin
          e_valid = 1;
          e_prs = sm[int'(in_rs_addr)];
          e_prt = sm[int'(in_rt_addr)];
          e_old = sm[rd];
          e_prd = 0;
          if (need) begin
            sm[rd] = pick;
            fr[pick] = 1'b0;
            e_prd = pick;
          end
        end else begin
          e_valid = 0;
        end
      end
      if (cdo) begin
        int old = am[cv];
        am[cv] = cp;
        if (old != 0) fr[old] = 1'b1;
      end
    end
  endtask

  // Model advances on the same edges as the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock();
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_in_ready", int'(in_ready), model_ready());
      checkOutput("cmp_out_valid", int'(out_valid), e_valid);
      checkOutput("cmp_prs", int'(out_prs_addr), e_prs);
      checkOutput("cmp_prt", int'(out_prt_addr), e_prt);
      checkOutput("cmp_prd", int'(out_prd_addr), e_prd);
      checkOutput("cmp_prd_old", int'(out_prd_old), e_old);
`ifdef RENAME_FREE_COUNT_EN
      checkOutput("cmp_free_count", int'(free_count), model_free_total());
`endif
    end
  end

  task automatic applyStimulus(input bit v, input int rs, input int rt, input bit en,
                               input int rd, input bit st, input bit fl,
                               input bit cv, input int cvreg, input int cpreg);
    in_valid     = v;
    in_rs_addr   = VW'(rs);
    in_rt_addr   = VW'(rt);
    in_rd_enable = en;
    in_rd_addr   = VW'(rd);
    stall        = st;
    flush        = fl;
    commit_valid = cv;
    commit_vreg  = VW'(cvreg);
    commit_preg  = PW'(cpreg);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rename(input int rs, input int rt, input int rd);
    applyStimulus(1, rs, rt, 1, rd, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic doReset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic checkFreeLiteral(input string name, input int expected);
    checkOutput(name, model_free_total(), expected);
`ifdef RENAME_FREE_COUNT_EN
    checkOutput({name, "_dut"}, int'(free_count), expected);
`endif
  endtask

  int saved_free;

  initial begin
    idle();
    step();
    step();
    rst_n = 1'b1;

    // Reset values
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_prd", int'(out_prd_addr), 0);
    checkFreeLiteral("rst_free", 32);

    // Test 1: first rename
    rename(1, 2, 3);
    checkOutput("t1_valid", int'(out_valid), 1);
    checkOutput("t1_prs", int'(out_prs_addr), 1);
    checkOutput("t1_prt", int'(out_prt_addr), 2);
    checkOutput("t1_prd", int'(out_prd_addr), 32);
    checkOutput("t1_old", int'(out_prd_old), 3);
    checkFreeLiteral("t1_free", 31);
    idle();
    step();
    checkOutput("t1_idle_valid", int'(out_valid), 0);
    checkOutput("t1_idle_hold_prd", int'(out_prd_addr), 32);

    // Test 2: back-to-back dependents
    doReset();
    rename(0, 0, 3);
    rename(3, 0, 3);
    checkOutput("t2_prs", int'(out_prs_addr), 32);
    checkOutput("t2_prd", int'(out_prd_addr), 33);
    checkOutput("t2_old", int'(out_prd_old), 32);

    // Test 3: register 0 and commit of vreg 0, then stall with commit
    saved_free = model_free_total();
    rename(0, 0, 0);
    checkOutput("t3_prd0", int'(out_prd_addr), 0);
    checkOutput("t3_prs0", int'(out_prs_addr), 0);
    checkOutput("t3_old0", int'(out_prd_old), 0);
    checkFreeLiteral("t3_free_same", 30);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 40);
    step();
    checkFreeLiteral("t3_commit0_free", saved_free);
    rename(0, 0, 9);
    checkOutput("t3_prd_next", int'(out_prd_addr), 34);
    applyStimulus(1, 1, 1, 1, 10, 1, 0, 1, 3, 32);
    step();
    checkOutput("t3_stall_valid", int'(out_valid), 1);
    checkOutput("t3_stall_prd", int'(out_prd_addr), 34);
    rename(0, 0, 10);
    checkOutput("t3_freed_alloc", int'(out_prd_addr), 3);

    // Test 4: drain the free list
    doReset();
    for (int i = 1; i < 32; i++) rename(i, 0, i);
    rename(1, 0, 1);
    checkOutput("t4_last_prd", int'(out_prd_addr), 63);
    checkFreeLiteral("t4_empty", 0);
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    checkOutput("t4_ready_full", int'(in_ready), 0);
    step();
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    checkOutput("t4_ready_noalloc", int'(in_ready), 1);
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 1, 1, 32);
    checkOutput("t4_ready_commit_cycle", int'(in_ready), 0);
    step();
    applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    checkOutput("t4_ready_after", int'(in_ready), 1);
    step();
    checkOutput("t4_prd_recycled", int'(out_prd_addr), 1);

    // Test 5a: commit then flush
    doReset();
    rename(0, 0, 4);
    rename(0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, 32);
    step();
    applyStimulus(1, 4, 0, 1, 7, 1, 1, 0, 0, 0);
    step();
    checkOutput("t5a_flush_valid", int'(out_valid), 0);
    checkFreeLiteral("t5a_free", 32);
    rename(4, 0, 7);
    checkOutput("t5a_prs", int'(out_prs_addr), 32);
    checkOutput("t5a_prd", int'(out_prd_addr), 4);

    // Test 5b: commit in the flush cycle
    doReset();
    rename(0, 0, 4);
    rename(0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 4, 32);
    step();
    checkOutput("t5b_flush_valid", int'(out_valid), 0);
    checkFreeLiteral("t5b_free", 32);
    rename(4, 0, 7);
    checkOutput("t5b_prs", int'(out_prs_addr), 32);
    checkOutput("t5b_prd", int'(out_prd_addr), 4);

    // Test 6: reset mid-stream during a stall
    doReset();
    rename(1, 2, 3);
    rename(3, 0, 4);
    applyStimulus(1, 3, 4, 1, 5, 1, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_valid", int'(out_valid), 0);
    checkOutput("t6_prs", int'(out_prs_addr), 0);
    checkOutput("t6_prd", int'(out_prd_addr), 0);
    checkOutput("t6_old", int'(out_prd_old), 0);
    step();
    idle();
    rst_n = 1'b1;
    rename(3, 0, 6);
    checkOutput("t6_prs_after", int'(out_prs_addr), 3);
    checkOutput("t6_prd_after", int'(out_prd_addr), 32);

    idle();
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
